// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared AXI4-Lite definitions for the request arbiter and the
//                interconnect blocks that will reuse its pieces.
//                Contents: response codes, default protection value and the
//                arbiter transaction state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

    // AXI4-Lite BRESP / RRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access
    localparam logic [2:0] DEFAULT_PROT = 3'b000;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_B_WAIT = 3'd2,
        ST_RD     = 3'd3,
        ST_R_WAIT = 3'd4,
        ST_RSP    = 3'd5
    } state_e;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_req_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Combinational two-way round-robin grant. A lone requester
//                always wins; when both request, the one that did not win
//                last time is granted.
//  Ports       : req_i        in  2  request lines
//                last_grant_i in  1  index of the previously served requester
//                gnt_o        out 2  one-hot (or zero) grant
//                gnt_id_o     out 1  index of the granted requester
//                gnt_valid_o  out 1  a grant is being made
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o,
    output logic       gnt_valid_o
);

    always_comb begin
        gnt_id_o    = 1'b0;
        gnt_valid_o = |req_i;
        case (req_i)
            2'b01:   gnt_id_o = 1'b0;
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ~last_grant_i;
            default: gnt_id_o = 1'b0;
        endcase
        gnt_o = 2'b00;
        if (gnt_valid_o) begin
            gnt_o = gnt_id_o ? 2'b10 : 2'b01;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/axil_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axil_req_arbiter
//  Description : Shares one AXI4-Lite master port between two simple
//                register-access requesters. Each accepted request becomes
//                exactly one AXI4-Lite write or read; the response is returned
//                to the issuing requester as a one-cycle pulse. One
//                transaction is outstanding at a time.
//  Ports       : clk, reset               clock, synchronous active-high reset
//                req_valid/ready/write    per-requester handshake and direction
//                req_addr/wdata/wstrb     per-requester packed slices
//                rsp_valid                per-requester response pulse
//                rsp_rdata, rsp_resp      shared response payload
//                AW*/W*/B*/AR*/R*         AXI4-Lite master port
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_req_arbiter
    import axil_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [2:0]  PROT       = DEFAULT_PROT
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_write,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   req_wstrb,
    output logic [1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic [1:0]                  rsp_resp,

    output logic [ADDR_WIDTH-1:0]       AWADDR,
    output logic [2:0]                  AWPROT,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    output logic [DATA_WIDTH-1:0]       WDATA,
    output logic [DATA_WIDTH/8-1:0]     WSTRB,
    output logic                        WVALID,
    input  logic                        WREADY,
    input  logic [1:0]                  BRESP,
    input  logic                        BVALID,
    output logic                        BREADY,
    output logic [ADDR_WIDTH-1:0]       ARADDR,
    output logic [2:0]                  ARPROT,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    input  logic [DATA_WIDTH-1:0]       RDATA,
    input  logic [1:0]                  RRESP,
    input  logic                        RVALID,
    output logic                        RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    gnt_q, gnt_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;

    logic [1:0]              arb_gnt;
    logic                    arb_id;
    logic                    arb_valid;

    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [STRB_WIDTH-1:0]   sel_wstrb;
    logic                    sel_write;

    rr_arbiter2 u_rr_arbiter2 (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (arb_gnt),
        .gnt_id_o     (arb_id),
        .gnt_valid_o  (arb_valid)
    );

    // Payload of whichever requester the arbiter is currently granting
    assign sel_addr  = arb_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                              : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = arb_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                              : req_wdata[DATA_WIDTH-1:0];
    assign sel_wstrb = arb_id ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                              : req_wstrb[STRB_WIDTH-1:0];
    assign sel_write = arb_id ? req_write[1] : req_write[0];

    // The AXI payload is driven straight from the captured request so it is
    // stable for the whole life of each VALID.
    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign AWPROT    = PROT;
    assign ARPROT    = PROT;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;

        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        AWVALID      = 1'b0;
        WVALID       = 1'b0;
        BREADY       = 1'b0;
        ARVALID      = 1'b0;
        RREADY       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = arb_gnt;
                if (arb_valid) begin
                    gnt_d     = arb_id;
                    write_d   = sel_write;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    wstrb_d   = sel_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = sel_write ? ST_WR : ST_RD;
                end
            end

            ST_WR: begin
                // AW and W are independent channels; each VALID stays up
                // until its own handshake, in whichever order they complete.
                AWVALID   = ~aw_done_q;
                WVALID    = ~w_done_q;
                aw_done_d = aw_done_q | AWREADY;
                w_done_d  = w_done_q | WREADY;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_B_WAIT;
                end
            end

            ST_B_WAIT: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    resp_d  = BRESP;
                    rdata_d = '0;
                    state_d = ST_RSP;
                end
            end

            ST_RD: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    state_d = ST_R_WAIT;
                end
            end

            ST_R_WAIT: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    rdata_d = RDATA;
                    resp_d  = RRESP;
                    state_d = ST_RSP;
                end
            end

            ST_RSP: begin
                rsp_valid    = gnt_q ? 2'b10 : 2'b01;
                last_grant_d = gnt_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            // Pretend requester 1 was served last so requester 0 wins first
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= RESP_OKAY;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
        end
    end

endmodule : axil_req_arbiter
`default_nettype wire

// File: tb/tb_axil_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_req_arbiter
//  Description : Self-checking bench for axil_req_arbiter. Two requester
//                drivers, a configurable-latency AXI4-Lite slave with its own
//                memory, and a transaction-level reference model that predicts
//                grants and responses every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_req_arbiter;

    localparam int          AW   = 8;
    localparam int          DW   = 32;
    localparam logic [2:0]  PROT = 3'b000;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
    } req_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [1:0]      req_write = 2'b00;
    logic [2*AW-1:0] req_addr  = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [7:0]      req_wstrb = '0;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   AWADDR, ARADDR;
    logic [2:0]      AWPROT, ARPROT;
    logic            AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic            AWREADY = 0, WREADY = 0, BVALID = 0, ARREADY = 0, RVALID = 0;
    logic [DW-1:0]   WDATA;
    logic [3:0]      WSTRB;
    logic [1:0]      BRESP = 0, RRESP = 0;
    logic [DW-1:0]   RDATA = 0;

    axil_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(PROT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Reference arbitration rule: lone requester wins, a tie goes to the one
    // that was not served most recently.
    function automatic logic [1:0] model_grant(input logic [1:0] v, input bit last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    // ---------------- slave configuration ----------------
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    // ---------------- handshake observations (negedge) ----------------
    bit            hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    acc;

    // ---------------- requester drivers ----------------
    req_t rq0[$], rq1[$];
    req_t cur0 = '0, cur1 = '0;
    bit   have0 = 0, have1 = 0;

    task automatic push(input int id, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] s);
        req_t r;
        r = '{write: wr, addr: a, wdata: d, wstrb: s};
        if (id == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    always @(posedge clk) begin
        #1;
        if (reset) begin
            have0 = 0; have1 = 0;
            rq0.delete(); rq1.delete();
        end else begin
            if (have0 && acc[0]) have0 = 0;
            if (have1 && acc[1]) have1 = 0;
            if (!have0 && rq0.size() != 0) begin cur0 = rq0.pop_front(); have0 = 1; end
            if (!have1 && rq1.size() != 0) begin cur1 = rq1.pop_front(); have1 = 1; end
        end
        req_valid = {have1, have0};
        req_write = {cur1.write, cur0.write};
        req_addr  = {cur1.addr, cur0.addr};
        req_wdata = {cur1.wdata, cur0.wdata};
        req_wstrb = {cur1.wstrb, cur0.wstrb};
    end

    // ---------------- AXI4-Lite slave ----------------
    bit [DW-1:0] smem [256];
    bit          aw_got, w_got, b_pend, r_pend;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [AW-1:0] s_awaddr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [3:0]    s_wstrb;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            BRESP = 0; RRESP = 0; RDATA = 0;
        end else begin
            if (hs_aw) begin aw_got = 1; s_awaddr = m_awaddr; aw_cnt = 0; end
            if (hs_w)  begin w_got = 1; s_wdata = m_wdata; s_wstrb = m_wstrb; w_cnt = 0; end
            if (hs_b)  begin b_pend = 0; aw_got = 0; w_got = 0; end
            if (hs_ar) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; s_rdata = smem[m_araddr]; end
            if (hs_r)  r_pend = 0;
            if (aw_got && w_got && !b_pend) begin
                smem[s_awaddr] = merge(smem[s_awaddr], s_wdata, s_wstrb);
                b_pend = 1; b_cnt = 0;
            end
            AWREADY = AWVALID && !aw_got && (aw_cnt >= aw_dly);
            if (AWVALID && !aw_got && !AWREADY) aw_cnt++;
            WREADY = WVALID && !w_got && (w_cnt >= w_dly);
            if (WVALID && !w_got && !WREADY) w_cnt++;
            ARREADY = ARVALID && !r_pend && (ar_cnt >= ar_dly);
            if (ARVALID && !r_pend && !ARREADY) ar_cnt++;
            BVALID = b_pend && (b_cnt >= b_dly);
            if (b_pend && !BVALID) b_cnt++;
            RVALID = r_pend && (r_cnt >= r_dly);
            if (r_pend && !RVALID) r_cnt++;
            BRESP = BVALID ? bresp_cfg : 2'b00;
            RRESP = RVALID ? rresp_cfg : 2'b00;
            RDATA = RVALID ? s_rdata : '0;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit [DW-1:0]   mmem [256];
    bit            busy = 0, first = 0, rsp_due = 0, last_served = 1;
    bit            cur_id, cur_write;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata, exp_rdata;
    logic [3:0]    cur_wstrb;
    logic [1:0]    exp_resp;
    int            cnt_aw, cnt_w, cnt_b, cnt_ar, cnt_r;
    int            acc_cyc, aw_cyc, w_cyc, rsp_cyc, n_rsp = 0;
    int            last_id;
    logic [DW-1:0] last_rdata;
    logic [1:0]    last_resp;
    int            grant_log[$];
    bit            p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;

    always @(negedge clk) begin
        req_t r;
        hs_aw = AWVALID && AWREADY;
        hs_w  = WVALID && WREADY;
        hs_b  = BVALID && BREADY;
        hs_ar = ARVALID && ARREADY;
        hs_r  = RVALID && RREADY;
        if (hs_aw) m_awaddr = AWADDR;
        if (hs_w)  begin m_wdata = WDATA; m_wstrb = WSTRB; end
        if (hs_ar) m_araddr = ARADDR;
        acc = req_valid & req_ready;

        if (reset) begin
            busy = 0; rsp_due = 0; first = 0; last_served = 1;
        end else begin
            check("req_ready", req_ready, busy ? 2'b00 : model_grant(req_valid, last_served));
            check("rsp_valid", rsp_valid, rsp_due ? (cur_id ? 2'b10 : 2'b01) : 2'b00);
            if (rsp_due) begin
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_resp", rsp_resp, exp_resp);
                if (cur_write)
                    check("wr_handshakes", {cnt_aw[3:0], cnt_w[3:0], cnt_b[3:0], cnt_ar[3:0]}, 16'h1110);
                else
                    check("rd_handshakes", {cnt_aw[3:0], cnt_ar[3:0], cnt_r[3:0]}, 12'h011);
                last_id = cur_id; last_rdata = rsp_rdata; last_resp = rsp_resp;
                rsp_cyc = cyc; n_rsp++;
                last_served = cur_id;
                busy = 0; rsp_due = 0;
            end
            if (busy) begin
                if (first) begin
                    check("valid_rise", {AWVALID, WVALID, ARVALID}, cur_write ? 3'b110 : 3'b001);
                    first = 0;
                end
                if (AWVALID) check("AWADDR", AWADDR, cur_addr);
                if (WVALID)  check("WDATA_WSTRB", {WDATA, WSTRB}, {cur_wdata, cur_wstrb});
                if (ARVALID) check("ARADDR", ARADDR, cur_addr);
                if (p_awv && !p_awr) check("AWVALID_held", AWVALID, 1'b1);
                if (p_wv && !p_wr)   check("WVALID_held", WVALID, 1'b1);
                if (p_arv && !p_arr) check("ARVALID_held", ARVALID, 1'b1);
                if (cur_write && cnt_aw == 1 && cnt_w == 1 && cnt_b == 0)
                    check("BREADY_held", BREADY, 1'b1);
                if (!cur_write && cnt_ar == 1 && cnt_r == 0)
                    check("RREADY_held", RREADY, 1'b1);
                check("PROT", {AWPROT, ARPROT}, {PROT, PROT});
                if (hs_aw) begin cnt_aw++; aw_cyc = cyc; end
                if (hs_w)  begin cnt_w++;  w_cyc  = cyc; end
                if (hs_b)  cnt_b++;
                if (hs_ar) cnt_ar++;
                if (hs_r)  cnt_r++;
                if (hs_b || hs_r) rsp_due = 1;
            end else begin
                check("bus_idle", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
            end
            if (acc != 2'b00) begin
                cur_id    = acc[1];
                r         = cur_id ? cur1 : cur0;
                cur_write = r.write; cur_addr = r.addr;
                cur_wdata = r.wdata; cur_wstrb = r.wstrb;
                if (r.write) begin
                    exp_rdata = '0; exp_resp = bresp_cfg;
                    mmem[r.addr] = merge(mmem[r.addr], r.wdata, r.wstrb);
                end else begin
                    exp_rdata = mmem[r.addr]; exp_resp = rresp_cfg;
                end
                busy = 1; first = 1;
                cnt_aw = 0; cnt_w = 0; cnt_b = 0; cnt_ar = 0; cnt_r = 0;
                acc_cyc = cyc;
                grant_log.push_back(int'(cur_id));
            end
        end
        p_awv = AWVALID; p_awr = AWREADY; p_wv = WVALID; p_wr = WREADY;
        p_arv = ARVALID; p_arr = ARREADY;
    end

    // ---------------- directed sequence ----------------
    int exp_rsp = 0;

    task automatic wait_rsp(input string name);
        int k;
        k = 0;
        while (n_rsp < exp_rsp && k < 100) begin @(negedge clk); k++; end
        check(name, n_rsp >= exp_rsp, 1'b1);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {req_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
        check("reset_payload", {AWADDR, ARADDR, WDATA, WSTRB}, 0);
        check("reset_rsp", {rsp_rdata, rsp_resp}, 0);
        @(posedge clk); #3 reset = 1'b0;

        // Write from requester 0, zero-wait slave
        push(0, 1, 8'h10, 32'hDEADBEEF, 4'hF); exp_rsp++;
        wait_rsp("t1_timeout");
        check("t1_latency", rsp_cyc - acc_cyc, 3);
        check("t1_aw_cycle", aw_cyc - acc_cyc, 1);
        check("t1_w_cycle", w_cyc - acc_cyc, 1);
        check("t1_id_resp", {last_id[0], last_resp}, 3'b000);

        // Read back from requester 1
        push(1, 0, 8'h10, 32'h0, 4'h0); exp_rsp++;
        wait_rsp("t2_timeout");
        check("t2_araddr", m_araddr, 8'h10);
        check("t2_rdata", last_rdata, 32'hDEADBEEF);
        check("t2_id", last_id, 1);
        check("t2_latency", rsp_cyc - acc_cyc, 3);

        // Both requesters contend continuously
        grant_log.delete();
        push(0, 1, 8'h20, 32'h11111111, 4'hF);
        push(0, 1, 8'h24, 32'h22222222, 4'hF);
        push(1, 0, 8'h20, 32'h0, 4'h0);
        push(1, 0, 8'h24, 32'h0, 4'h0);
        exp_rsp += 4;
        wait_rsp("t3_timeout");
        check("t3_grants", {grant_log.size() == 4 ? 1'b1 : 1'b0,
                            4'(grant_log.size() > 3 ? {grant_log[0][0], grant_log[1][0],
                                                       grant_log[2][0], grant_log[3][0]} : 4'hF)},
              5'b1_0101);
        check("t3_rdata", last_rdata, 32'h22222222);

        // W completes three cycles before AW, partial strobes
        aw_dly = 3;
        push(0, 1, 8'h30, 32'h12345678, 4'h5); exp_rsp++;
        wait_rsp("t4_timeout");
        check("t4_aw_after_w", aw_cyc - w_cyc, 3);
        check("t4_latency", rsp_cyc - acc_cyc, 6);
        aw_dly = 0;
        push(1, 0, 8'h30, 32'h0, 4'h0); exp_rsp++;
        wait_rsp("t4r_timeout");
        check("t4_rdata_strobed", last_rdata, 32'h00340078);

        // Slow B, then a read returning SLVERR
        b_dly = 5;
        push(0, 1, 8'h40, 32'hCAFEF00D, 4'hF); exp_rsp++;
        wait_rsp("t5_timeout");
        check("t5_latency", rsp_cyc - acc_cyc, 8);
        b_dly = 0; rresp_cfg = 2'b10;
        push(1, 0, 8'h40, 32'h0, 4'h0); exp_rsp++;
        wait_rsp("t5r_timeout");
        check("t5_rresp", last_resp, 2'b10);
        check("t5_rdata", last_rdata, 32'hCAFEF00D);
        rresp_cfg = 2'b00;

        // Reset while waiting for R
        r_dly = 10;
        push(0, 0, 8'h10, 32'h0, 4'h0);
        k = 0;
        while (!RREADY && k < 40) begin @(negedge clk); k++; end
        check("t6_reached_rwait", RREADY, 1'b1);
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("t6_ctrl_after_reset", {req_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
        check("t6_payload_after_reset", {AWADDR, WDATA, rsp_rdata, rsp_resp}, 0);
        @(posedge clk); #3 reset = 1'b0;
        r_dly = 0;
        check("t6_no_rsp_for_aborted", n_rsp, exp_rsp);
        push(0, 0, 8'h10, 32'h0, 4'h0); exp_rsp++;
        wait_rsp("t6_timeout");
        check("t6_rdata", last_rdata, 32'hDEADBEEF);
        check("t6_id_latency", {last_id[3:0], 4'(rsp_cyc - acc_cyc)}, 8'h03);

        repeat (3) @(negedge clk);
        check("final_idle", {busy, rsp_due}, 2'b00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axil_req_arbiter
`default_nettype wire
